// File: rtl/gerador_base_tempo_pkg.sv
// -----------------------------------------------------------------------------
// base_tempo_pkg
// Shared definitions for the gerador_base_tempo time base:
//   - timer_state_e : timer FSM state encoding (IDLE / RUN)
//   - calc_div      : clock divider CLK_HZ / TICK_HZ (0 if TICK_HZ is 0)
//   - calc_cnt_w    : width of a counter that must hold 0 .. DIV-1
//   - div_is_valid  : legality of the divider (exact, even, >= 2)
// -----------------------------------------------------------------------------
package base_tempo_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } timer_state_e;

  function automatic int calc_div(input int clk_hz, input int tick_hz);
    if (tick_hz <= 0) begin
      return 0;
    end else begin
      return clk_hz / tick_hz;
    end
  endfunction

  // A width of at least 1 keeps the prescaler declarable even for DIV = 2.
  function automatic int calc_cnt_w(input int div);
    if (div <= 2) begin
      return 1;
    end else begin
      return $clog2(div);
    end
  endfunction

  function automatic bit div_is_valid(input int clk_hz, input int tick_hz);
    int div;
    if (tick_hz <= 0 || clk_hz <= 0) begin
      return 1'b0;
    end else begin
      div = clk_hz / tick_hz;
      return ((clk_hz % tick_hz) == 0) && (div >= 2) && ((div % 2) == 0);
    end
  endfunction

endpackage

// File: rtl/gerador_base_tempo_prescaler.sv
// -----------------------------------------------------------------------------
// prescaler_tick
// Divides the system clock by DIV while enable_i is high.
// Ports:
//   clk       in   system clock, posedge
//   rst_n     in   synchronous active-low reset
//   enable_i  in   1 = count, 0 = hold everything
//   clear_i   in   synchronous phase restart (pre_cnt, tick, square -> 0)
//   tick_o    out  registered one-cycle strobe every DIV enabled cycles
//   square_o  out  registered 50% square wave, period DIV
//   wrap_o    out  combinational: this edge is a wrap edge (tick being set)
// clear_i has priority over counting: a wrap that coincides with a clear
// is swallowed, so no tick and no wrap event are produced on that edge.
// -----------------------------------------------------------------------------
module prescaler_tick
  import base_tempo_pkg::*;
#(
  parameter int DIV   = 50,
  parameter int CNT_W = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable_i,
  input  logic clear_i,
  output logic tick_o,
  output logic square_o,
  output logic wrap_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2 - 1);

  logic [CNT_W-1:0] pre_cnt_q, pre_cnt_d;
  logic             tick_q, tick_d;
  logic             square_q, square_d;
  logic             wrap;

  // Next-state for the divider counter, tick strobe and square wave.
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    tick_d    = 1'b0;
    square_d  = square_q;
    wrap      = 1'b0;
    if (clear_i) begin
      pre_cnt_d = '0;
      square_d  = 1'b0;
    end else if (enable_i) begin
      if (pre_cnt_q == CNT_LAST) begin
        pre_cnt_d = '0;
        tick_d    = 1'b1;
        wrap      = 1'b1;
        square_d  = ~square_q;
      end else begin
        pre_cnt_d = pre_cnt_q + CNT_W'(1);
        // Mid-period toggle: square is high while pre_cnt >= DIV/2.
        if (pre_cnt_q == CNT_HALF) begin
          square_d = ~square_q;
        end else begin
          square_d = square_q;
        end
      end
    end else begin
      pre_cnt_d = pre_cnt_q;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt_q <= '0;
      tick_q    <= 1'b0;
      square_q  <= 1'b0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      tick_q    <= tick_d;
      square_q  <= square_d;
    end
  end

  assign tick_o   = tick_q;
  assign square_o = square_q;
  assign wrap_o   = wrap;

endmodule

// File: rtl/gerador_base_tempo.sv
// -----------------------------------------------------------------------------
// gerador_base_tempo
// Time base: one-cycle tick every DIV = CLK_HZ/TICK_HZ enabled cycles, a 50%
// square wave, a free-running tick counter and a tick-resolution countdown
// timer with start/abort/done handshake.
// Ports:
//   clk, rst_n            clock (posedge) and synchronous active-low reset
//   enable                1 = run; 0 = prescaler, timer and us_count frozen
//   tick, square          registered strobe / square wave from the prescaler
//   us_count[TIMER_W]     tick counter, wraps to 0
//   start, abort          one-cycle requests (abort wins)
//   load_us[TIMER_W]      timer length in ticks, sampled with start
//   busy, done            timer running / one-cycle expiry pulse
//   remaining_us[TIMER_W] ticks left, 0 when idle
// Configuration macro TIMER_ALIGN_EN: when defined, an accepted start
// (start without abort) restarts the prescaler phase so expiry lands exactly
// N*DIV cycles after the start edge. Without it the prescaler free-runs.
// -----------------------------------------------------------------------------
module gerador_base_tempo
  import base_tempo_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1_000_000,
  parameter int TIMER_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  output logic               tick,
  output logic               square,
  output logic [TIMER_W-1:0] us_count,
  input  logic               start,
  input  logic               abort,
  input  logic [TIMER_W-1:0] load_us,
  output logic               busy,
  output logic               done,
  output logic [TIMER_W-1:0] remaining_us
);

  localparam int DIV   = calc_div(CLK_HZ, TICK_HZ);
  localparam int CNT_W = calc_cnt_w(DIV);

  if (!div_is_valid(CLK_HZ, TICK_HZ)) begin : g_div_check
    $error("gerador_base_tempo: CLK_HZ/TICK_HZ must be an even integer >= 2");
  end

  timer_state_e       state_q, state_d;
  logic [TIMER_W-1:0] remaining_q, remaining_d;
  logic [TIMER_W-1:0] us_count_q, us_count_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               tick_event;
  logic               phase_clear;

`ifdef TIMER_ALIGN_EN
  assign phase_clear = start & ~abort;
`else
  assign phase_clear = 1'b0;
`endif

  prescaler_tick #(
    .DIV   (DIV),
    .CNT_W (CNT_W)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable_i (enable),
    .clear_i  (phase_clear),
    .tick_o   (tick),
    .square_o (square),
    .wrap_o   (tick_event)
  );

  // Tick counter advances on every prescaler wrap.
  always_comb begin
    us_count_d = us_count_q;
    if (tick_event) begin
      us_count_d = us_count_q + TIMER_W'(1);
    end else begin
      us_count_d = us_count_q;
    end
  end

  // Timer next-state: abort > start > countdown.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    if (abort) begin
      state_d     = ST_IDLE;
      remaining_d = '0;
      busy_d      = 1'b0;
    end else if (start) begin
      if (load_us == '0) begin
        // Zero-length request expires immediately without ever being busy.
        state_d     = ST_IDLE;
        remaining_d = '0;
        busy_d      = 1'b0;
        done_d      = 1'b1;
      end else begin
        // Also the restart path in RUN: a coincident tick is not counted.
        state_d     = ST_RUN;
        remaining_d = load_us;
        busy_d      = 1'b1;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (tick_event) begin
            if (remaining_q == TIMER_W'(1)) begin
              state_d     = ST_IDLE;
              remaining_d = '0;
              busy_d      = 1'b0;
              done_d      = 1'b1;
            end else begin
              remaining_d = remaining_q - TIMER_W'(1);
            end
          end else begin
            remaining_d = remaining_q;
          end
        end
        ST_IDLE: begin
          remaining_d = '0;
          busy_d      = 1'b0;
        end
        default: begin
          state_d     = ST_IDLE;
          remaining_d = '0;
          busy_d      = 1'b0;
        end
      endcase
    end
  end

  // Timer, counter and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      us_count_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      us_count_q  <= us_count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign us_count     = us_count_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign remaining_us = remaining_q;

endmodule

// File: tb/tb_gerador_base_tempo.sv
// -----------------------------------------------------------------------------
// tb_gerador_base_tempo
// Two instances share all stimulus: the default build (TIMER_W=16) and a
// TIMER_W=4 build used to observe the us_count wrap. Loads never exceed 15
// so both timers behave identically. A reference model derived from elapsed
// enabled cycles and tick deadlines predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_gerador_base_tempo;

  localparam int DIV = 50;
`ifdef TIMER_ALIGN_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] load_us = 16'd0;

  logic        tick, square, busy, done;
  logic [15:0] us_count, remaining_us;
  logic        tick4, square4, busy4, done4;
  logic [3:0]  us_count4, remaining4;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  gerador_base_tempo dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .tick(tick), .square(square),
    .us_count(us_count), .start(start), .abort(abort), .load_us(load_us),
    .busy(busy), .done(done), .remaining_us(remaining_us)
  );

  gerador_base_tempo #(.TIMER_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .tick(tick4), .square(square4),
    .us_count(us_count4), .start(start), .abort(abort), .load_us(load_us[3:0]),
    .busy(busy4), .done(done4), .remaining_us(remaining4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phase = enabled edges since last phase restart,
  // ticks = total tick events, timer = deadline in tick units.
  int     m_phase = 0;
  longint m_ticks = 0;
  longint m_end   = 0;
  bit     m_tick  = 1'b0;
  bit     m_run   = 1'b0;
  bit     m_done  = 1'b0;

  always @(posedge clk) begin
    bit acc, clr, ev;
    if (!rst_n) begin
      m_phase = 0; m_ticks = 0; m_end = 0;
      m_tick = 1'b0; m_run = 1'b0; m_done = 1'b0;
    end else begin
      acc = start && !abort;
      clr = ALIGN && acc;
      ev  = !clr && enable && (((m_phase + 1) % DIV) == 0);
      if (clr) m_phase = 0;
      else if (enable) m_phase = m_phase + 1;
      m_tick = ev;
      if (ev) m_ticks = m_ticks + 1;
      m_done = 1'b0;
      if (abort) begin
        m_run = 1'b0;
      end else if (start) begin
        if (load_us == 16'd0) begin
          m_done = 1'b1;
          m_run  = 1'b0;
        end else begin
          m_run = 1'b1;
          m_end = m_ticks + longint'(load_us);
        end
      end else if (m_run && ev && (m_ticks == m_end)) begin
        m_done = 1'b1;
        m_run  = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    longint exp_rem;
    bit     exp_sq;
    if (chk_en) begin
      exp_rem = m_run ? (m_end - m_ticks) : 0;
      exp_sq  = (m_phase % DIV) >= (DIV / 2);
      check("tick",      tick,         m_tick);
      check("square",    square,       exp_sq);
      check("us_count",  us_count,     m_ticks % 65536);
      check("busy",      busy,         m_run);
      check("done",      done,         m_done);
      check("remaining", remaining_us, exp_rem);
      check("tick4",     tick4,        m_tick);
      check("square4",   square4,      exp_sq);
      check("us_count4", us_count4,    m_ticks % 16);
      check("busy4",     busy4,        m_run);
      check("done4",     done4,        m_done);
      check("remaining4", remaining4,  exp_rem);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a timer of n ticks; optionally drop enable for off_len cycles
  // beginning off_at cycles after the start edge. lat = edges start->done.
  task automatic run_timer(input logic [15:0] n, input int off_at, input int off_len,
                           output int lat);
    start = 1'b1; load_us = n;
    step();
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    check("rem_after_start", remaining_us, n);
    lat = -1;
    for (int i = 1; i <= 3000; i++) begin
      if (off_len > 0 && i == off_at) enable = 1'b0;
      if (off_len > 0 && i == off_at + off_len) enable = 1'b1;
      step();
      if (done) begin
        lat = i;
        break;
      end
    end
    enable = 1'b1;
  endtask

  initial begin
    int lat;
    int n_done;
    bit found;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("reset_tick", tick, 1'b0);
    check("reset_us", us_count, 16'd0);
    check("reset_busy", busy, 1'b0);

    // Free-running time base from reset release.
    rst_n = 1'b1; enable = 1'b1;
    for (int k = 1; k <= 800; k++) begin
      step();
      if (k == 24)  check("sq_k24", square, 1'b0);
      if (k == 25)  check("sq_k25", square, 1'b1);
      if (k == 49)  check("tick_k49", tick, 1'b0);
      if (k == 50)  check("tick_k50", tick, 1'b1);
      if (k == 50)  check("sq_k50", square, 1'b0);
      if (k == 100) check("tick_k100", tick, 1'b1);
      if (k == 150) check("tick_k150", tick, 1'b1);
      if (k == 150) check("us_k150", us_count, 16'd3);
      if (k == 750) check("us4_k750", us_count4, 4'd15);
      if (k == 800) check("us4_wrap", us_count4, 4'd0);
      if (k == 800) check("us_k800", us_count, 16'd16);
    end

    // 10-tick timer.
    run_timer(16'd10, 0, 0, lat);
`ifdef TIMER_ALIGN_EN
    check("lat10", lat, 500);
`else
    check("lat10_in_range", (lat >= 451) && (lat <= 500), 1'b1);
`endif
    check("rem_at_done", remaining_us, 16'd0);
    step();

    // Zero-length request.
    start = 1'b1; load_us = 16'd0;
    step();
    start = 1'b0;
    check("zero_done", done, 1'b1);
    check("zero_busy", busy, 1'b0);
    step();
    check("zero_done_once", done, 1'b0);

    // Abort at cycle 200.
    start = 1'b1; load_us = 16'd10;
    step();
    start = 1'b0;
    repeat (199) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_rem", remaining_us, 16'd0);
    n_done = 0;
    for (int i = 0; i < 600; i++) begin
      step();
      if (done) n_done++;
    end
    check("abort_no_done", n_done, 0);
    start = 1'b1; abort = 1'b1; load_us = 16'd10;
    step();
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle", busy, 1'b0);

    // Stretch by 100 disabled cycles.
    run_timer(16'd10, 100, 100, lat);
`ifdef TIMER_ALIGN_EN
    check("lat_stretch", lat, 600);
`else
    check("lat_stretch_in_range", (lat >= 551) && (lat <= 600), 1'b1);
`endif
    step();

    // Restart at remaining=3.
    start = 1'b1; load_us = 16'd10;
    step();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (remaining_us == 16'd3) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check("reached_rem3", found, 1'b1);
    start = 1'b1; load_us = 16'd10;
    step();
    start = 1'b0;
    check("reload_rem", remaining_us, 16'd10);
    check("reload_busy", busy, 1'b1);

    // Reset mid-run.
    repeat (100) step();
    rst_n = 1'b0;
    step();
    check("rst_busy", busy, 1'b0);
    check("rst_rem", remaining_us, 16'd0);
    check("rst_us", us_count, 16'd0);
    check("rst_square", square, 1'b0);
    rst_n = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 6000; i++) begin
      rst_n   = ($urandom % 700) != 0;
      enable  = ($urandom % 8) != 0;
      start   = ($urandom % 150) == 0;
      abort   = ($urandom % 400) == 0;
      load_us = 16'($urandom % 7);
      step();
    end
    rst_n = 1'b1; start = 1'b0; abort = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
